// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared FSM state type, default datapath width and the saturation all-ones helper
package add_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int WIDTH_DEF = 8;
  function automatic logic [63:0] all_ones(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/add_arb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req after last (ports: req, last, en in; one-hot gnt, encoded idx out)
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/add_arb_ctrl.sv
// add_arb_ctrl: round-robin shared 8-bit adder sequencer (clk/rst_n, ena, sat_en, req valid/ready/a/b per requester; rsp valid/ready/sum/carry/id, busy)
module add_arb_ctrl import add_arb_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = 2,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   sat_en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);
  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));
  state_t state;
  logic [IDW-1:0] last_grant, gidx;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic sat_q, hs;
  logic [WIDTH:0] full;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .last(last_grant),
    .en  (ena),
    .gnt (gnt),
    .idx (gidx)
  );
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign hs = |(req_valid & req_ready);
  assign full = {1'b0, a_q} + {1'b0, b_q};
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      a_q <= '0;
      b_q <= '0;
      sat_q <= 1'b0;
      rsp_sum <= '0;
      rsp_carry <= 1'b0;
      rsp_id <= '0;
    end else if (state == IDLE && hs) begin
      a_q <= req_a[int'(gidx)*WIDTH +: WIDTH];
      b_q <= req_b[int'(gidx)*WIDTH +: WIDTH];
      sat_q <= sat_en;
      last_grant <= gidx;
      rsp_id <= gidx;
      state <= EXEC;
    end else if (state == EXEC) begin
      rsp_sum <= (sat_q && full[WIDTH]) ? ONES : full[WIDTH-1:0];
      rsp_carry <= full[WIDTH];
      state <= RESP;
    end else if (state == RESP && rsp_ready)
      state <= IDLE;
endmodule

// File: tb/tb_add_arb_ctrl.sv
// tb_add_arb_ctrl: directed self-checking bench for add_arb_ctrl with immediate assertions
module tb_add_arb_ctrl;
  logic clk = 0, rst_n = 0, ena = 0, sat_en = 0, rsp_ready = 0;
  logic [1:0] req_valid = '0, req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_carry, busy;
  logic [7:0] rsp_sum;
  logic [0:0] rsp_id;
  int checks = 0, errors = 0;
  add_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sat_en(sat_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input int id, input logic [7:0] a, input logic [7:0] b, input logic sat,
                    input logic [7:0] es, input logic ec);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    sat_en = sat;
    req_valid = 2'(1 << id);
    #1 chk("op_ready", req_ready, 32'(1 << id));
    tick();
    req_valid = '0;
    sat_en = ~sat;
    chk("op_exec_valid", rsp_valid, 0);
    chk("op_exec_busy", busy, 1);
    chk("op_exec_ready", req_ready, 0);
    tick();
    chk("op_valid", rsp_valid, 1);
    chk("op_sum", rsp_sum, es);
    chk("op_carry", rsp_carry, ec);
    chk("op_id", rsp_id, id);
    tick();
    chk("op_done", rsp_valid, 0);
    chk("op_idle", busy, 0);
  endtask
  initial begin
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_carry", rsp_carry, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    ena = 1;
    rsp_ready = 1;
    op(0, 8'h12, 8'h34, 0, 8'h46, 0);
    req_a = {8'd10, 8'd1};
    req_b = {8'd20, 8'd2};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_ready", req_ready, (k % 2 == 0) ? 2 : 1);
      tick();
      tick();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, (k % 2 == 0) ? 1 : 0);
      chk("rr_sum", rsp_sum, (k % 2 == 0) ? 30 : 3);
      tick();
    end
    req_valid = '0;
    op(1, 8'hF0, 8'h20, 0, 8'h10, 1);
    op(1, 8'hF0, 8'h20, 1, 8'hFF, 1);
    op(1, 8'hFF, 8'h01, 1, 8'hFF, 1);
    op(1, 8'h7F, 8'h01, 1, 8'h80, 0);
    rsp_ready = 0;
    req_a = {8'h00, 8'h55};
    req_b = {8'h00, 8'h11};
    sat_en = 0;
    req_valid = 2'b11;
    #1 chk("hold_ready0", req_ready, 1);
    tick();
    req_valid = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, 8'h66);
      chk("hold_id", rsp_id, 0);
      chk("hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("hold_next_ready", req_ready, 2);
    req_valid = '0;
    #1 chk("drop_ready", req_ready, 0);
    tick();
    chk("drop_busy", busy, 0);
    ena = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1 chk("ena0_ready", req_ready, 0);
      chk("ena0_busy", busy, 0);
      tick();
    end
    ena = 1;
    req_valid = 2'b01;
    req_a[7:0] = 8'h21;
    req_b[7:0] = 8'h43;
    #1 chk("ena1_ready", req_ready, 1);
    tick();
    ena = 0;
    req_valid = 2'b11;
    tick();
    chk("ena_drop_valid", rsp_valid, 1);
    chk("ena_drop_sum", rsp_sum, 8'h64);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("ena_drop_ready", req_ready, 0);
      chk("ena_drop_busy", busy, 0);
      tick();
    end
    ena = 1;
    rsp_ready = 0;
    req_valid = 2'b10;
    req_a[15:8] = 8'h03;
    req_b[15:8] = 8'h04;
    tick();
    req_valid = '0;
    tick();
    chk("prerst_valid", rsp_valid, 1);
    #2 rst_n = 0;
    #1 chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sum", rsp_sum, 0);
    rst_n = 1;
    req_valid = 2'b11;
    #1 chk("postrst_ready", req_ready, 1);
    tick();
    req_valid = '0;
    tick();
    chk("postrst_id", rsp_id, 0);
    chk("postrst_sum", rsp_sum, 8'h64);
    rsp_ready = 1;
    tick();
    chk("postrst_done", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
